// File: rtl/rotary_gen.sv
// Quadrature generator: emits a commanded number of detents on ROT_A/ROT_B
// with optional contact chatter at each phase edge.
module rotary_gen #(
  parameter int unsigned DWELL  = 8,
  parameter int unsigned BOUNCE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_dir,
  input  logic [7:0] cmd_count,
  output logic       ROT_A,
  output logic       ROT_B,
  output logic       busy,
  output logic       done,
  output logic [7:0] steps_left
);

  localparam int unsigned    CntW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DWELL - 1);

  typedef enum logic [2:0] {StIdle, StPh1, StPh2, StPh3, StPh4, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic [7:0]      steps_q, steps_d;
  logic [1:0]      rot_q, rot_d;
  logic            phase_end;
  logic            in_bounce;
  logic [1:0]      new_ab, old_ab;

  assign phase_end = (cnt_q == CntMax);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      steps_q <= 8'd0;
      rot_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      steps_q <= steps_d;
      rot_q   <= rot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    steps_d = steps_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          dir_d   = cmd_dir;
          steps_d = cmd_count;
          cnt_d   = '0;
          state_d = (cmd_count == 8'd0) ? StDone : StPh1;
        end
      end
      StPh1, StPh2, StPh3: begin
        cnt_d = phase_end ? '0 : cnt_q + CntW'(1);
        if (phase_end) begin
          state_d = (state_q == StPh1) ? StPh2 : (state_q == StPh2) ? StPh3 : StPh4;
        end
      end
      StPh4: begin
        cnt_d = phase_end ? '0 : cnt_q + CntW'(1);
        if (phase_end) begin
          steps_d = steps_q - 8'd1;
          state_d = (steps_q == 8'd1) ? StDone : StPh1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Chatter replays the previous phase value on odd dwell indices inside the bounce window.
  if (BOUNCE > 0) begin : g_bounce
    assign in_bounce = (cnt_d < CntW'(BOUNCE)) & cnt_d[0];
  end else begin : g_clean
    assign in_bounce = 1'b0;
  end

  // Line values are computed from the next state so ROT_A/ROT_B come straight from flops.
  always_comb begin
    new_ab = 2'b00;
    old_ab = 2'b00;
    unique case (state_d)
      StPh1: begin
        new_ab = dir_d ? 2'b10 : 2'b01;
        old_ab = 2'b00;
      end
      StPh2: begin
        new_ab = 2'b11;
        old_ab = dir_d ? 2'b10 : 2'b01;
      end
      StPh3: begin
        new_ab = dir_d ? 2'b01 : 2'b10;
        old_ab = 2'b11;
      end
      StPh4: begin
        new_ab = 2'b00;
        old_ab = dir_d ? 2'b01 : 2'b10;
      end
      default: begin
        new_ab = 2'b00;
        old_ab = 2'b00;
      end
    endcase
    rot_d = in_bounce ? old_ab : new_ab;
  end

  always_comb begin
    cmd_ready  = (state_q == StIdle);
    busy       = (state_q == StPh1) || (state_q == StPh2) ||
                 (state_q == StPh3) || (state_q == StPh4);
    done       = (state_q == StDone);
    ROT_A      = rot_q[1];
    ROT_B      = rot_q[0];
    steps_left = steps_q;
  end

endmodule

// File: tb/tb_rotary_gen.sv
// Bench for rotary_gen: command table, random commands against a timeline model,
// reset abort, bounce shape and a behavioural quadrature decoder loopback.
module tb_rotary_gen;

  localparam int DW  = 4;
  localparam int DWB = 8;
  localparam int BNB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cmd_valid, cmd_dir, cmd_ready, rot_a, rot_b, busy, done;
  logic [7:0] cmd_count, steps_left;
  logic       rst_b, valid_b, dir_b, ready_b, rot_a_b, rot_b_b, busy_b, done_b;
  logic [7:0] count_b, steps_b;

  rotary_gen #(.DWELL(DW), .BOUNCE(0)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_count(cmd_count), .ROT_A(rot_a), .ROT_B(rot_b), .busy(busy), .done(done),
    .steps_left(steps_left)
  );

  rotary_gen #(.DWELL(DWB), .BOUNCE(BNB)) dut_b (
    .clk(clk), .rst(rst_b), .cmd_valid(valid_b), .cmd_ready(ready_b), .cmd_dir(dir_b),
    .cmd_count(count_b), .ROT_A(rot_a_b), .ROT_B(rot_b_b), .busy(busy_b), .done(done_b),
    .steps_left(steps_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // AB line values for phase p (0..3) of a detent.
  function automatic logic [1:0] phase_val(input bit dir, input int p);
    logic [1:0] r [4];
    logic [1:0] l [4];
    r = '{2'b10, 2'b11, 2'b01, 2'b00};
    l = '{2'b01, 2'b11, 2'b10, 2'b00};
    return dir ? r[p] : l[p];
  endfunction

  // Expected AB j cycles after the accept edge.
  function automatic logic [1:0] model_ab(input bit dir, input int n, input int dwell,
                                          input int bounce, input int j);
    int p, k;
    if (j >= 4 * n * dwell) return 2'b00;
    p = (j / dwell) % 4;
    k = j % dwell;
    if (k < bounce && (k % 2) == 1) return phase_val(dir, (p + 3) % 4);
    return phase_val(dir, p);
  endfunction

  // Issue one command on dut and check every cycle until cmd_ready returns.
  task automatic run_cmd(input bit dir, input int n, output int done_at,
                         output logic [1:0] first_ab);
    int guard;
    int last;
    done_at = -1;
    first_ab = 2'bxx;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir = dir;
    cmd_count = 8'(n);
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      check("ready_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last = 4 * n * DW;
    for (int j = 0; j <= last + 1; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      if (j == 0) first_ab = {rot_a, rot_b};
      if (done && done_at < 0) done_at = j;
      check($sformatf("ab[d%0d n%0d j%0d]", dir, n, j), {rot_a, rot_b},
            model_ab(dir, n, DW, 0, j));
      check($sformatf("steps[j%0d]", j), steps_left,
            (j < last) ? n - j / (4 * DW) : 0);
      check($sformatf("busy[j%0d]", j), busy, j < last);
      check($sformatf("done[j%0d]", j), done, j == last);
      check($sformatf("ready[j%0d]", j), cmd_ready, j == last + 1);
      // Garbage command traffic that must be ignored while not idle.
      cmd_valid = (j < last) ? 1'($urandom) : 1'b0;
      cmd_dir = 1'($urandom);
      cmd_count = 8'($urandom);
    end
    cmd_valid = 1'b0;
  endtask

  // Behavioural quadrature decoder and up/down adder for the loopback test.
  logic       dec_clr;
  logic [1:0] prev_ab;
  int         acc, ev_r, ev_l, sum;

  function automatic int pos_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int step_of(input logic [1:0] a, input logic [1:0] b);
    int d;
    d = (pos_of(b) - pos_of(a) + 4) % 4;
    return (d == 1) ? 1 : (d == 3) ? -1 : 0;
  endfunction

  always @(posedge clk) begin
    if (dec_clr) begin
      prev_ab <= {rot_a, rot_b};
      acc <= 0;
      ev_r <= 0;
      ev_l <= 0;
      sum <= 100;
    end else begin
      prev_ab <= {rot_a, rot_b};
      if ({rot_a, rot_b} != prev_ab) begin
        if (acc + step_of(prev_ab, {rot_a, rot_b}) == 4) begin
          acc <= 0;
          ev_r <= ev_r + 1;
          sum <= sum + 1;
        end else if (acc + step_of(prev_ab, {rot_a, rot_b}) == -4) begin
          acc <= 0;
          ev_l <= ev_l + 1;
          sum <= sum - 1;
        end else begin
          acc <= acc + step_of(prev_ab, {rot_a, rot_b});
        end
      end
    end
  end

  typedef struct {
    bit         dir;
    int         n;
    logic [1:0] exp_first;
    int         exp_done;
  } vec_t;

  initial begin
    vec_t       vecs [6];
    int         done_at, pulses, guard;
    logic [1:0] first_ab;
    logic [7:0] ph1_a, ph2_b;

    vecs[0] = '{dir: 1'b1, n: 1, exp_first: 2'b10, exp_done: 16};
    vecs[1] = '{dir: 1'b0, n: 3, exp_first: 2'b01, exp_done: 48};
    vecs[2] = '{dir: 1'b1, n: 0, exp_first: 2'b00, exp_done: 0};
    vecs[3] = '{dir: 1'b0, n: 1, exp_first: 2'b01, exp_done: 16};
    vecs[4] = '{dir: 1'b1, n: 2, exp_first: 2'b10, exp_done: 32};
    vecs[5] = '{dir: 1'b0, n: 0, exp_first: 2'b00, exp_done: 0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_count = 8'd0;
    rst_b = 1'b1; valid_b = 1'b0; dir_b = 1'b0; count_b = 8'd0;
    dec_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ab", {rot_a, rot_b}, 2'b00);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_steps", steps_left, 8'd0);
    rst = 1'b0;
    rst_b = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_cmd(vecs[i].dir, vecs[i].n, done_at, first_ab);
      check($sformatf("vec%0d_first_ab", i), first_ab, vecs[i].exp_first);
      check($sformatf("vec%0d_done_at", i), done_at, vecs[i].exp_done);
    end

    for (int i = 0; i < 6; i++) begin
      run_cmd(1'($urandom), int'($urandom_range(0, 5)), done_at, first_ab);
    end

    // Reset in the middle of a 5-detent command, with cmd_valid asserted alongside.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_count = 8'd5;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (28) @(posedge clk);
    #1;
    check("pre_rst_ab", {rot_a, rot_b}, model_ab(1'b1, 5, DW, 0, 28));
    rst = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ab", {rot_a, rot_b}, 2'b00);
    check("abort_ready", cmd_ready, 1'b1);
    check("abort_steps", steps_left, 8'd0);
    check("abort_busy", busy, 1'b0);
    rst = 1'b0;
    cmd_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    check("abort_idle_ab", {rot_a, rot_b}, 2'b00);
    run_cmd(1'b1, 1, done_at, first_ab);
    check("post_rst_first", first_ab, 2'b10);
    check("post_rst_done_at", done_at, 16);

    // Bounce shape on the DWELL=8, BOUNCE=3 instance.
    ph1_a = 8'b1111_1101;
    ph2_b = 8'b1111_1101;
    @(negedge clk);
    valid_b = 1'b1; dir_b = 1'b1; count_b = 8'd1;
    @(posedge clk);
    #1;
    valid_b = 1'b0;
    for (int j = 0; j < 4 * DWB; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("bab[j%0d]", j), {rot_a_b, rot_b_b}, model_ab(1'b1, 1, DWB, BNB, j));
      if (j < 8) begin
        check($sformatf("ph1_a[%0d]", j), rot_a_b, ph1_a[j]);
        check($sformatf("ph1_b[%0d]", j), rot_b_b, 1'b0);
      end else if (j < 16) begin
        check($sformatf("ph2_b[%0d]", j - 8), rot_b_b, ph2_b[j - 8]);
        check($sformatf("ph2_a[%0d]", j - 8), rot_a_b, 1'b1);
      end
    end
    guard = 0;
    while (!done_b && guard < 10) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("bounce_done", done_b, 1'b1);
    check("bounce_done_at", guard, 1);

    // Loopback into the behavioural decoder.
    @(negedge clk);
    dec_clr = 1'b1;
    @(negedge clk);
    dec_clr = 1'b0;
    run_cmd(1'b1, 5, done_at, first_ab);
    check("loop_right_ev", ev_r, 5);
    check("loop_right_wrong", ev_l, 0);
    check("loop_mid_sum", sum, 105);
    run_cmd(1'b0, 5, done_at, first_ab);
    check("loop_left_ev", ev_l, 5);
    check("loop_left_wrong", ev_r, 5);
    check("loop_sum", sum, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
